// File: rtl/fwrdk2j_err_pkg.sv
// Shared definitions for the fwrdk2j error monitor: run-state encoding,
// datapath width, default accumulator width and a popcount helper.
// Latency: n/a (package). Backpressure: n/a.
// The popcount helper is only referenced when HAMMING_ERR_EN is defined.
package fwrdk2j_err_pkg;

    localparam int DATA_W    = 64;   // {out1,out0} from either fwrdk2j
    localparam int SUM_W_DEF = 84;   // default error-distance accumulator width
    localparam int POP_W     = 7;    // popcount of a 64-bit word: 0..64

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [POP_W-1:0] popcount64(input logic [DATA_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/fwrdk2j_err_diff.sv
// Stage 1 of the error monitor: absolute error distance, mismatch flag and
// (with HAMMING_ERR_EN) the popcount of exact ^ approx, all registered.
// Latency: 1 cycle from accept to s1_* outputs. Backpressure: none; the
// caller only presents a sample when it is accepted (fire).
// Ports: clk, rst_n (async active-low), clr (drop stage contents), fire
// (sample accepted this cycle), exact/approx (64-bit unsigned inputs),
// s1_vld/s1_ed/s1_mis (registered result), s1_pop (HAMMING_ERR_EN only).
module fwrdk2j_err_diff
    import fwrdk2j_err_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              fire,
    input  logic [DATA_W-1:0] exact,
    input  logic [DATA_W-1:0] approx,
    output logic              s1_vld,
    output logic [DATA_W-1:0] s1_ed,
    output logic              s1_mis
`ifdef HAMMING_ERR_EN
    ,
    output logic [POP_W-1:0]  s1_pop
`endif
);

    logic [DATA_W-1:0] ed;

    // Subtract the smaller from the larger so the distance never wraps.
    always_comb begin
        ed = '0;
        if (exact >= approx) begin
            ed = exact - approx;
        end else begin
            ed = approx - exact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_ed  <= '0;
            s1_mis <= 1'b0;
        end else begin
            s1_vld <= fire && !clr;
            if (fire) begin
                s1_ed  <= ed;
                s1_mis <= (exact != approx);
            end
        end
    end

`ifdef HAMMING_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pop <= '0;
        end else if (fire) begin
            s1_pop <= popcount64(exact ^ approx);
        end
    end
`endif

endmodule

// File: rtl/fwrdk2j_err_monitor.sv
// Error-statistics monitor comparing exact vs approximate fwrdk2j outputs
// over NUM_SAMPLES accepted pairs: mismatch count, max and sum of |exact-approx|.
// Latency: an accepted sample shows in the statistics 2 cycles later; done
// rises 2 cycles after the final accept. Backpressure: in_ready is high only
// in RUN; samples offered in any other state are not consumed.
// Ports: clk, rst_n (async active-low), start (run pulse), in_valid/in_ready,
// exact/approx (64-bit), busy, done, err_count, max_ed, sum_ed.
// Optional: define HAMMING_ERR_EN to add ham_sum, the saturating sum of
// popcount(exact ^ approx).
module fwrdk2j_err_monitor
    import fwrdk2j_err_pkg::*;
#(
    parameter int NUM_SAMPLES = 1000000,
    parameter int SUM_W       = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] exact,
    input  logic [DATA_W-1:0] approx,
    output logic              busy,
    output logic              done,
    output logic [31:0]       err_count,
    output logic [DATA_W-1:0] max_ed,
    output logic [SUM_W-1:0]  sum_ed
`ifdef HAMMING_ERR_EN
    ,
    output logic [SUM_W-1:0]  ham_sum
`endif
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    // Accumulate one bit wider than the larger operand so the saturation
    // compare sees the true sum, including when SUM_W < DATA_W.
    localparam int ACC_W = ((SUM_W > DATA_W) ? SUM_W : DATA_W) + 1;
    localparam logic [ACC_W-1:0] SAT_EXT  = {{(ACC_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  sample_cnt;
    logic              drain_cnt;
    logic              fire;
    logic              start_ok;
    logic              last_fire;

    logic              s1_vld;
    logic [DATA_W-1:0] s1_ed;
    logic              s1_mis;

    logic [ACC_W-1:0]  sum_ext;
    logic [SUM_W-1:0]  sum_sat;
    logic              err_inc;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign fire      = in_valid && in_ready;
    // start only counts from a quiescent state; a pulse mid-run is ignored.
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign last_fire = fire && (sample_cnt == LAST_IDX);

    // ------------------------------------------------------------------
    // Run control
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (last_fire) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt) state_nxt = DONE;
            DONE:    if (start)     state_nxt = RUN;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            drain_cnt  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                sample_cnt <= '0;
            end else if (fire) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            // Low on the first DRAIN cycle (arrives from RUN), high on the
            // second, which is when the FSM leaves for DONE.
            drain_cnt <= (state == DRAIN);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: distance / mismatch
    // ------------------------------------------------------------------
`ifdef HAMMING_ERR_EN
    logic [POP_W-1:0]  s1_pop;
    logic [ACC_W-1:0]  ham_ext;
    logic [SUM_W-1:0]  ham_sat;
`endif

    fwrdk2j_err_diff u_diff (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .fire   (fire),
        .exact  (exact),
        .approx (approx),
        .s1_vld (s1_vld),
        .s1_ed  (s1_ed),
        .s1_mis (s1_mis)
`ifdef HAMMING_ERR_EN
        ,
        .s1_pop (s1_pop)
`endif
    );

    // ------------------------------------------------------------------
    // Stage 2: statistics
    // ------------------------------------------------------------------
    always_comb begin
        sum_ext = ACC_W'(sum_ed) + ACC_W'(s1_ed);
        sum_sat = sum_ext[SUM_W-1:0];
        if (sum_ext > SAT_EXT) begin
            sum_sat = SAT_EXT[SUM_W-1:0];
        end
        err_inc = s1_mis && (err_count != 32'hFFFF_FFFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (start_ok) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else if (s1_vld) begin
            if (err_inc) begin
                err_count <= err_count + 32'd1;
            end
            if (s1_ed > max_ed) begin
                max_ed <= s1_ed;
            end
            sum_ed <= sum_sat;
        end
    end

`ifdef HAMMING_ERR_EN
    always_comb begin
        ham_ext = ACC_W'(ham_sum) + ACC_W'(s1_pop);
        ham_sat = ham_ext[SUM_W-1:0];
        if (ham_ext > SAT_EXT) begin
            ham_sat = SAT_EXT[SUM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ham_sum <= '0;
        end else if (start_ok) begin
            ham_sum <= '0;
        end else if (s1_vld) begin
            ham_sum <= ham_sat;
        end
    end
`endif

endmodule

// File: tb/tb_fwrdk2j_err_monitor.sv
// Self-checking bench for fwrdk2j_err_monitor. Three instances:
// u0 (NUM_SAMPLES=4, SUM_W=84), u1 (NUM_SAMPLES=3), u2 (NUM_SAMPLES=2, SUM_W=8).
// Expected statistics come from a list-based model of accepted pairs.
module tb_fwrdk2j_err_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_s [3];
    logic        vld_s   [3];
    logic [63:0] ex_s    [3];
    logic [63:0] ap_s    [3];
    logic        rdy_s   [3];
    logic        busy_s  [3];
    logic        done_s  [3];
    logic [31:0] cnt_s   [3];
    logic [63:0] max_s   [3];
    logic [83:0] sum0;
    logic [83:0] sum1;
    logic [7:0]  sum2;
`ifdef HAMMING_ERR_EN
    logic [83:0] ham0;
    logic [83:0] ham1;
    logic [7:0]  ham2;
`endif

    int tests = 0;
    int fails = 0;

    logic [63:0] q_e [$];
    logic [63:0] q_a [$];
    logic [63:0] pe  [4];
    logic [63:0] pa  [4];

    fwrdk2j_err_monitor #(.NUM_SAMPLES(4), .SUM_W(84)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(vld_s[0]),
        .in_ready(rdy_s[0]), .exact(ex_s[0]), .approx(ap_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .err_count(cnt_s[0]), .max_ed(max_s[0]), .sum_ed(sum0)
`ifdef HAMMING_ERR_EN
        , .ham_sum(ham0)
`endif
    );

    fwrdk2j_err_monitor #(.NUM_SAMPLES(3), .SUM_W(84)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(vld_s[1]),
        .in_ready(rdy_s[1]), .exact(ex_s[1]), .approx(ap_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .err_count(cnt_s[1]), .max_ed(max_s[1]), .sum_ed(sum1)
`ifdef HAMMING_ERR_EN
        , .ham_sum(ham1)
`endif
    );

    fwrdk2j_err_monitor #(.NUM_SAMPLES(2), .SUM_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(vld_s[2]),
        .in_ready(rdy_s[2]), .exact(ex_s[2]), .approx(ap_s[2]), .busy(busy_s[2]),
        .done(done_s[2]), .err_count(cnt_s[2]), .max_ed(max_s[2]), .sum_ed(sum2)
`ifdef HAMMING_ERR_EN
        , .ham_sum(ham2)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] sum_of(input int k);
        case (k)
            0:       return 128'(sum0);
            1:       return 128'(sum1);
            default: return 128'(sum2);
        endcase
    endfunction

`ifdef HAMMING_ERR_EN
    function automatic logic [127:0] ham_of(input int k);
        case (k)
            0:       return 128'(ham0);
            1:       return 128'(ham1);
            default: return 128'(ham2);
        endcase
    endfunction
`endif

    task automatic chk_ctl(input int k, input string tag, input logic rdy, input logic bsy, input logic dn);
        chk({tag, ".in_ready"}, 128'(rdy_s[k]),  128'(rdy));
        chk({tag, ".busy"},     128'(busy_s[k]), 128'(bsy));
        chk({tag, ".done"},     128'(done_s[k]), 128'(dn));
    endtask

    task automatic chk_stats(input int k, input string tag, input logic [127:0] c,
                             input logic [127:0] m, input logic [127:0] s);
        chk({tag, ".err_count"}, 128'(cnt_s[k]), c);
        chk({tag, ".max_ed"},    128'(max_s[k]), m);
        chk({tag, ".sum_ed"},    sum_of(k),      s);
    endtask

    // Reference: statistics over the list of accepted pairs, with the sums
    // clipped to the all-ones value of an sw-bit accumulator.
    task automatic check_run(input int k, input string tag, input int sw);
        int           c;
        logic [127:0] mx, sm, hm, ed, satv;
        c = 0; mx = '0; sm = '0; hm = '0;
        satv = (128'd1 << sw) - 128'd1;
        for (int i = 0; i < q_e.size(); i++) begin
            ed = (q_e[i] > q_a[i]) ? 128'(q_e[i] - q_a[i]) : 128'(q_a[i] - q_e[i]);
            if (ed != 0) c++;
            if (ed > mx) mx = ed;
            sm = sm + ed;
            hm = hm + 128'($countones(q_e[i] ^ q_a[i]));
        end
        if (sm > satv) sm = satv;
        if (hm > satv) hm = satv;
        chk_stats(k, tag, 128'(c), mx, sm);
`ifdef HAMMING_ERR_EN
        chk({tag, ".ham_sum"}, ham_of(k), hm);
`endif
    endtask

    task automatic wait_done(input int k, input string tag);
        int w;
        w = 0;
        while (done_s[k] !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk({tag, ".done_reached"}, 128'(done_s[k]), 128'd1);
    endtask

    task automatic pulse_start(input int k);
        start_s[k] = 1'b1;
        tick();
        start_s[k] = 1'b0;
    endtask

    // Start a run on instance k and feed pe/pa[0..n-1] back to back.
    task automatic run_pairs(input int k, input int n, input string tag);
        q_e.delete();
        q_a.delete();
        pulse_start(k);
        for (int i = 0; i < n; i++) begin
            vld_s[k] = 1'b1;
            ex_s[k]  = pe[i];
            ap_s[k]  = pa[i];
            q_e.push_back(pe[i]);
            q_a.push_back(pa[i]);
            tick();
        end
        vld_s[k] = 1'b0;
        wait_done(k, tag);
    endtask

    task automatic gen_pair(output logic [63:0] e, output logic [63:0] a);
        int unsigned mode;
        mode = $urandom_range(0, 2);
        e = {$urandom, $urandom};
        case (mode)
            0:       a = e;
            1:       a = e + 64'($urandom_range(0, 1000)) - 64'd500;
            default: a = {$urandom, $urandom};
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0; vld_s[k] = 1'b0; ex_s[k] = '0; ap_s[k] = '0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state of every instance
        for (int k = 0; k < 3; k++) begin
            chk_ctl(k, $sformatf("reset.u%0d", k), 1'b0, 1'b0, 1'b0);
            chk_stats(k, $sformatf("reset.u%0d", k), 128'd0, 128'd0, 128'd0);
        end

        // Directed 3-sample run with cycle-exact pipeline/done timing
        pulse_start(1);
        chk_ctl(1, "n3.run", 1'b1, 1'b1, 1'b0);
        vld_s[1] = 1'b1; ex_s[1] = 64'd10; ap_s[1] = 64'd7;
        tick();
        chk_stats(1, "n3.acc1+1", 128'd0, 128'd0, 128'd0);
        ex_s[1] = 64'd5; ap_s[1] = 64'd9;
        tick();
        chk_stats(1, "n3.acc1+2", 128'd1, 128'd3, 128'd3);
        ex_s[1] = 64'd0; ap_s[1] = 64'd0;
        tick();
        vld_s[1] = 1'b0;
        chk_stats(1, "n3.acc2+2", 128'd2, 128'd4, 128'd7);
        chk_ctl(1, "n3.drain1", 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl(1, "n3.drain2", 1'b0, 1'b1, 1'b0);
        tick();
        chk_ctl(1, "n3.done", 1'b0, 1'b0, 1'b1);
        chk_stats(1, "n3.final", 128'd2, 128'd4, 128'd7);
        // Offered samples in DONE must not disturb the statistics
        vld_s[1] = 1'b1; ex_s[1] = 64'd1; ap_s[1] = 64'd100;
        repeat (3) tick();
        vld_s[1] = 1'b0;
        chk_stats(1, "n3.stable", 128'd2, 128'd4, 128'd7);
        chk_ctl(1, "n3.stable", 1'b0, 1'b0, 1'b1);

        // SUM_W=8 saturation: two distances of 255
        pe[0] = 64'd0; pa[0] = 64'd255;
        pe[1] = 64'd0; pa[1] = 64'd255;
        run_pairs(2, 2, "sat8");
        check_run(2, "sat8", 8);
        chk("sat8.sum_abs", sum_of(2), 128'd255);

        // Randomized runs on u0
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) gen_pair(pe[i], pa[i]);
            run_pairs(0, 4, $sformatf("rand%0d", r));
            check_run(0, $sformatf("rand%0d", r), 84);
        end

        // in_valid toggling every cycle: only 4 accepts may be counted
        q_e.delete(); q_a.delete();
        pulse_start(0);
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            vld_s[0] = (c % 2 == 0);
            gen_pair(ex_s[0], ap_s[0]);
            if (vld_s[0] && rdy_s[0]) begin
                acc++;
                q_e.push_back(ex_s[0]);
                q_a.push_back(ap_s[0]);
            end
            tick();
        end
        vld_s[0] = 1'b0;
        chk("toggle.accepts", 128'(acc), 128'd4);
        chk("toggle.in_ready", 128'(rdy_s[0]), 128'd0);
        wait_done(0, "toggle");
        check_run(0, "toggle", 84);

        // Reset in the middle of a run
        q_e.delete(); q_a.delete();
        pulse_start(0);
        vld_s[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ex_s[0] = 64'(100 + i); ap_s[0] = 64'd3;
            q_e.push_back(ex_s[0]); q_a.push_back(ap_s[0]);
            tick();
        end
        vld_s[0] = 1'b0;
        repeat (2) tick();
        check_run(0, "midrun.partial", 84);
        rst_n = 1'b0;
        #1;
        chk_ctl(0, "midrun.rst", 1'b0, 1'b0, 1'b0);
        chk_stats(0, "midrun.rst", 128'd0, 128'd0, 128'd0);
        tick();
        rst_n = 1'b1;
        vld_s[0] = 1'b1; ex_s[0] = 64'd9; ap_s[0] = 64'd1;
        repeat (3) tick();
        vld_s[0] = 1'b0;
        chk_ctl(0, "postrst.idle", 1'b0, 1'b0, 1'b0);
        chk_stats(0, "postrst.idle", 128'd0, 128'd0, 128'd0);

        // start while busy is ignored: all four samples must be counted
        q_e.delete(); q_a.delete();
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            vld_s[0] = 1'b1;
            start_s[0] = (i == 2);
            ex_s[0] = 64'(1000 * (i + 1)); ap_s[0] = 64'(7 * i + 1);
            q_e.push_back(ex_s[0]); q_a.push_back(ap_s[0]);
            tick();
        end
        vld_s[0] = 1'b0; start_s[0] = 1'b0;
        wait_done(0, "busystart");
        check_run(0, "busystart", 84);

        // start in DONE clears everything; then an all-equal run stays at zero
        pulse_start(0);
        chk_ctl(0, "doneclr", 1'b1, 1'b1, 1'b0);
        chk_stats(0, "doneclr", 128'd0, 128'd0, 128'd0);
        q_e.delete(); q_a.delete();
        for (int i = 0; i < 4; i++) begin
            vld_s[0] = 1'b1;
            ex_s[0] = {$urandom, $urandom}; ap_s[0] = ex_s[0];
            q_e.push_back(ex_s[0]); q_a.push_back(ap_s[0]);
            tick();
        end
        vld_s[0] = 1'b0;
        wait_done(0, "equal");
        chk_stats(0, "equal", 128'd0, 128'd0, 128'd0);

`ifdef HAMMING_ERR_EN
        pe[0] = 64'hFF; pa[0] = 64'h0F;
        for (int i = 1; i < 4; i++) begin pe[i] = 64'(i); pa[i] = 64'(i); end
        run_pairs(0, 4, "ham");
        chk("ham.ham_sum", ham_of(0), 128'd4);
        chk("ham.sum_ed", sum_of(0), 128'd240);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
